ysyx_22041207_mem_arb: RTL and testbench

- Arbitrates one shared memory port between the instruction-fetch stage (read-only) and the load/store unit (read/write).
- Runs one outstanding transaction at a time, sequenced by a 3-state FSM.
- Registers the response and returns it to the transaction's owner.
- Supports an IF-side flush, so a branch/jump redirect can discard a fetch that is already in flight.

---
 rtl/ysyx_22041207_mem_arb.sv | 178 +++++++++++++++++
 tb/tb_ysyx_22041207_mem_arb.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041207_mem_arb.sv
// Shared memory port arbiter between instruction fetch and the load/store unit.
// Define YSYX_22041207_ARB_RR_EN for round-robin arbitration (default: LSU priority).
module ysyx_22041207_mem_arb #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [AW-1:0]   lsu_addr,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_gnt,
  output logic            lsu_rvalid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int MW = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            own_lsu_q, own_lsu_d;
  logic            drop_q, drop_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            lsu_rvalid_q, lsu_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   lsu_rdata_q, lsu_rdata_d;

  logic            sel_lsu;
  logic            sel_if;
  logic            idle;
  logic            drop_now;

`ifdef YSYX_22041207_ARB_RR_EN
  logic            last_lsu_q, last_lsu_d;

  // On contention the side not granted last time wins.
  assign sel_lsu = lsu_req & ~(if_req & last_lsu_q);

  always_comb begin
    last_lsu_d = last_lsu_q;
    if (lsu_gnt) last_lsu_d = 1'b1;
    else if (if_gnt) last_lsu_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_lsu_q <= 1'b1;
    else        last_lsu_q <= last_lsu_d;
  end
`else
  assign sel_lsu = lsu_req;
`endif

  assign sel_if  = if_req & ~sel_lsu;
  assign idle    = (state_q == IDLE);
  // Grants are suppressed while reset is held so nothing leaks out.
  assign if_gnt  = rst_n & idle & sel_if;
  assign lsu_gnt = rst_n & idle & sel_lsu;

  assign drop_now = drop_q | (if_flush & ~own_lsu_q);

  always_comb begin
    state_d      = state_q;
    own_lsu_d    = own_lsu_q;
    drop_d       = 1'b0;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    if_rvalid_d  = 1'b0;
    lsu_rvalid_d = 1'b0;
    if_rdata_d   = if_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_gnt) begin
          own_lsu_d = 1'b1;
          addr_d    = lsu_addr;
          we_d      = lsu_we;
          wdata_d   = lsu_wdata;
          wmask_d   = lsu_wmask;
          state_d   = ISSUE;
        end else if (if_gnt) begin
          own_lsu_d = 1'b0;
          addr_d    = if_addr;
          we_d      = 1'b0;
          wdata_d   = '0;
          wmask_d   = '0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        drop_d = drop_now;
        if (mem_ready) state_d = WAIT;
      end
      WAIT: begin
        drop_d = drop_now;
        if (mem_rvalid) begin
          state_d = IDLE;
          drop_d  = 1'b0;
          if (own_lsu_q) begin
            lsu_rvalid_d = 1'b1;
            lsu_rdata_d  = we_q ? '0 : mem_rdata;
          end else if (!drop_now) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      own_lsu_q    <= 1'b0;
      drop_q       <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      if_rvalid_q  <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      own_lsu_q    <= own_lsu_d;
      drop_q       <= drop_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      if_rvalid_q  <= if_rvalid_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign mem_req    = (state_q == ISSUE);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wmask  = wmask_q;
  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_rdata  = lsu_rdata_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_ysyx_22041207_mem_arb.sv
// Directed bench for the memory arbiter: vector table plus
// hand-written reset, contention and flush sequences.
module tb_ysyx_22041207_mem_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic [63:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [7:0]  lsu_wmask;
  logic        lsu_gnt;
  logic        lsu_rvalid;
  logic [63:0] lsu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        busy;

  ysyx_22041207_mem_arb #(.AW(64), .DW(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_gnt    (lsu_gnt),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  typedef struct {
    bit          lsu;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          rdy_wait;
    int          rv_wait;
    logic [63:0] mrd;
    bit          flush;
    bit          flush_gnt;
  } vec_t;

  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  int   errors = 0;
  int   checks = 0;
  bit   last_lsu = 1'b1;
  vec_t tbl[7];
  vec_t va, vb;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit win_lsu(input bit i, input bit l);
`ifdef YSYX_22041207_ARB_RR_EN
    return l & ~(i & last_lsu);
`else
    return l;
`endif
  endfunction

  task automatic drive_if(input vec_t v);
    if_req  = 1'b1;
    if_addr = v.addr;
  endtask

  task automatic drive_lsu(input vec_t v);
    lsu_req   = 1'b1;
    lsu_we    = v.we;
    lsu_addr  = v.addr;
    lsu_wdata = v.wdata;
    lsu_wmask = v.wmask;
  endtask

  // Drop the request and scribble the fields to prove they were latched.
  task automatic release_side(input bit lsu);
    if (lsu) begin
      lsu_req   = 1'b0;
      lsu_we    = ~lsu_we;
      lsu_addr  = JUNK;
      lsu_wdata = JUNK;
      lsu_wmask = 8'hA5;
    end else begin
      if_req  = 1'b0;
      if_addr = JUNK;
    end
  endtask

  task automatic grant_one(input vec_t v);
    if (v.lsu) begin
      drive_lsu(v);
    end else begin
      drive_if(v);
      lsu_we    = 1'b1;
      lsu_wmask = 8'hFF;
      lsu_wdata = JUNK;
    end
    if_flush = v.flush_gnt;
    #1;
    chk("if_gnt", {63'd0, if_gnt}, {63'd0, !v.lsu});
    chk("lsu_gnt", {63'd0, lsu_gnt}, {63'd0, v.lsu});
    last_lsu = v.lsu;
    tick();
    release_side(v.lsu);
    if_flush = 1'b0;
  endtask

  // Entered one cycle into ISSUE; returns in the IDLE cycle with rvalid.
  task automatic complete(input vec_t v);
    for (int k = 0; k <= v.rdy_wait; k++) begin
      mem_ready = (k == v.rdy_wait);
      #1;
      chk("mem_req", {63'd0, mem_req}, 64'd1);
      chk("mem_addr", mem_addr, v.addr);
      chk("mem_we", {63'd0, mem_we}, {63'd0, v.lsu & v.we});
      chk("mem_wmask", {56'd0, mem_wmask}, v.lsu ? {56'd0, v.wmask} : 64'd0);
      if (v.lsu) chk("mem_wdata", mem_wdata, v.wdata);
      chk("gnt_busy", {62'd0, if_gnt, lsu_gnt}, 64'd0);
      tick();
    end
    mem_ready = 1'b0;
    for (int k = 0; k <= v.rv_wait; k++) begin
      if_flush   = v.flush && (k == 0);
      mem_rvalid = (k == v.rv_wait);
      mem_rdata  = (k == v.rv_wait) ? v.mrd : JUNK;
      #1;
      chk("wait_req", {63'd0, mem_req}, 64'd0);
      chk("wait_busy", {63'd0, busy}, 64'd1);
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = JUNK;
    if_flush   = 1'b0;
    chk("if_rvalid", {63'd0, if_rvalid}, {63'd0, !v.lsu && !v.flush});
    chk("lsu_rvalid", {63'd0, lsu_rvalid}, {63'd0, v.lsu});
    if (!v.lsu && !v.flush) chk("if_rdata", if_rdata, v.mrd);
    if (v.lsu) chk("lsu_rdata", lsu_rdata, v.we ? 64'd0 : v.mrd);
    chk("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic contention(input vec_t a, input vec_t b);
    bit wl;
    drive_if(a);
    drive_lsu(b);
    #1;
    wl = win_lsu(1'b1, 1'b1);
    chk("cont_if_gnt", {63'd0, if_gnt}, {63'd0, !wl});
    chk("cont_lsu_gnt", {63'd0, lsu_gnt}, {63'd0, wl});
    last_lsu = wl;
    tick();
    release_side(wl);
    complete(wl ? b : a);
    chk("loser_if_gnt", {63'd0, if_gnt}, {63'd0, wl});
    chk("loser_lsu_gnt", {63'd0, lsu_gnt}, {63'd0, !wl});
    last_lsu = !wl;
    tick();
    release_side(!wl);
    complete(wl ? a : b);
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, 0,
               64'h0000_0013, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F, 3, 0,
               64'h5555_5555, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 64'h8000_2008, 64'd0, 8'h00, 1, 2,
               64'h1122_3344_5566_7788, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 64'h8000_0004, 64'd0, 8'h00, 0, 2,
               64'h0000_AAAA, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 2, 1,
               64'h0010_0093, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 64'h0000_0010, 64'd0, 8'h00, 0, 1,
               64'h0000_CAFE, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 64'h8000_000C, 64'd0, 8'h00, 1, 0,
               64'h0000_7777, 1'b1, 1'b0};

    rst_n      = 1'b0;
    if_req     = 1'b1;
    if_addr    = 64'h8000_0000;
    if_flush   = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    lsu_addr   = '0;
    lsu_wdata  = '0;
    lsu_wmask  = '0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = JUNK;

    tick();
    tick();
    chk("rst_gnt", {62'd0, if_gnt, lsu_gnt}, 64'd0);
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rvalid", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_lsu_rdata", lsu_rdata, 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_ctl", {55'd0, mem_we, mem_wmask}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_if_gnt", {63'd0, if_gnt}, 64'd1);
    if_req = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      grant_one(tbl[i]);
      complete(tbl[i]);
      tick();
      chk("rvalid_pulse", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
    end

    va = tbl[0];
    vb = tbl[2];
    contention(va, vb);

    // Reset while waiting on memory: the late response must be dropped.
    grant_one(tbl[0]);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    last_lsu   = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_1234;
    #1;
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    tick();
    mem_rvalid = 1'b0;
    chk("post_rst_rvalid", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
    chk("post_rst_if_rdata", if_rdata, 64'd0);
    tick();
    chk("post_rst_rvalid2", {62'd0, if_rvalid, lsu_rvalid}, 64'd0);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);

    va = tbl[4];
    vb = tbl[1];
    contention(va, vb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
